// File: rtl/dds_pkg.sv
// Shared constants and types for the two-tone DDS stimulus generator.
package dds_pkg;
   localparam int PHASE_W_DEF = 24;
   localparam int ADDR_W_DEF  = 10;
   localparam int DATA_W_DEF  = 16;

   localparam logic [15:0] UNITY_AMP  = 16'h8000;
   localparam int          QTAB_DEPTH = 1 << (ADDR_W_DEF - 2);

   localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
   localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = ~SAT_MAX;

   localparam real PI = 3.14159265358979323846;

   typedef logic signed [DATA_W_DEF-1:0] sample_t;
endpackage

// File: rtl/two_tone_dds_if.sv
// Sample-request / sample-result bundle between the stimulus driver and the DDS.
interface two_tone_dds_if
   import dds_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
);
   logic                      sample_en;
   logic                      phase_clear;
   logic [PHASE_W-1:0]        fcw_a;
   logic [PHASE_W-1:0]        fcw_b;
   logic [15:0]               amp_a;
   logic [15:0]               amp_b;
   logic signed [DATA_W-1:0]  sample_out;
   logic                      sample_valid;
   logic                      clip;

   modport master (
      output sample_en, phase_clear, fcw_a, fcw_b, amp_a, amp_b,
      input  sample_out, sample_valid, clip
   );

   modport slave (
      input  sample_en, phase_clear, fcw_a, fcw_b, amp_a, amp_b,
      output sample_out, sample_valid, clip
   );
endinterface

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine table with registered read; folds the full-cycle address
// onto the quarter table (mirror on odd quadrants, negate on the lower half).
module sine_quarter_lut
   import dds_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        addr,
   output logic signed [DATA_W-1:0] value
);
   localparam int QW  = ADDR_W - 2;
   localparam int QD  = 1 << QW;
   localparam int AMP = (2 ** (DATA_W - 1)) - 1;

   // Half-step phase offset keeps every entry non-zero and the mirror exact.
   function automatic logic signed [DATA_W-1:0] entry(input int k);
      real x;
      x = 2.0 * PI * (real'(k) + 0.5) / real'(4 * QD);
      return DATA_W'(int'(real'(AMP) * $sin(x)));
   endfunction

   logic signed [DATA_W-1:0] rom [QD];

   for (genvar k = 0; k < QD; k++) begin : g_rom
      localparam logic signed [DATA_W-1:0] V = entry(k);
      assign rom[k] = V;
   end

   logic [1:0]    quad;
   logic [QW-1:0] idx;

   assign quad = addr[ADDR_W-1 -: 2];
   assign idx  = quad[0] ? ~addr[QW-1:0] : addr[QW-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) value <= '0;
      else      value <= quad[1] ? -rom[idx] : rom[idx];
   end
endmodule

// File: rtl/two_tone_dds.sv
// Two independent DDS tones, amplitude-scaled and summed with saturation.
// Optional TPDF dither on the sum is enabled by defining TWO_TONE_DDS_DITHER_EN.
module two_tone_dds
   import dds_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   two_tone_dds_if.slave bus
);
   localparam int STAGES = 3;
   localparam int TONE_W = DATA_W + 2;
   localparam int SUM_W  = DATA_W + 3;
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

   logic [STAGES:0]            vld_pipe;
   logic [1:0][PHASE_W-1:0]    fcw;
   logic [1:0][15:0]           amp_in;
   logic [1:0][TONE_W-1:0]     tone;
   logic signed [SUM_W-1:0]    sum;
   logic [DATA_W-1:0]          sat;
   logic                       clipped;
   logic [DATA_W-1:0]          sample_q;
   logic                       clip_q;

   assign fcw    = {bus.fcw_b, bus.fcw_a};
   assign amp_in = {bus.amp_b, bus.amp_a};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_pipe <= '0;
      else      vld_pipe <= {vld_pipe[STAGES-1:0], bus.sample_en};
   end

   for (genvar t = 0; t < 2; t++) begin : g_tone
      logic [PHASE_W-1:0]       phase;
      logic [ADDR_W-1:0]        addr;
      logic [15:0]              amp_s0, amp_s1;
      logic signed [DATA_W-1:0] lut;
      logic signed [DATA_W+16:0] prod;
      logic [TONE_W-1:0]        tone_q;

      // Clear beats increment; address is sampled from the pre-update phase.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            phase  <= '0;
            addr   <= '0;
            amp_s0 <= '0;
            amp_s1 <= '0;
            tone_q <= '0;
         end else begin
            if (bus.sample_en) begin
               addr   <= bus.phase_clear ? '0 : phase[PHASE_W-1 -: ADDR_W];
               amp_s0 <= amp_in[t];
            end
            if (bus.phase_clear)    phase <= '0;
            else if (bus.sample_en) phase <= phase + fcw[t];
            amp_s1 <= amp_s0;
            tone_q <= TONE_W'(prod >>> 15);
         end
      end

      assign prod    = lut * $signed({1'b0, amp_s1});
      assign tone[t] = tone_q;

      sine_quarter_lut #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lut (
         .clk   (clk),
         .rst   (rst),
         .addr  (addr),
         .value (lut)
      );
   end

`ifdef TWO_TONE_DDS_DITHER_EN
   logic [15:0]       lfsr;
   logic signed [1:0] dith;

   assign dith = $signed({1'b0, lfsr[0]}) - $signed({1'b0, lfsr[1]});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             lfsr <= 16'hACE1;
      else if (vld_pipe[2]) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign sum = SUM_W'($signed(tone[0])) + SUM_W'($signed(tone[1])) + SUM_W'(dith);
`else
   assign sum = SUM_W'($signed(tone[0])) + SUM_W'($signed(tone[1]));
`endif

   always_comb begin
      sat     = sum[DATA_W-1:0];
      clipped = 1'b0;
      if (sum > SAT_HI) begin
         sat     = SAT_HI[DATA_W-1:0];
         clipped = 1'b1;
      end else if (sum < SAT_LO) begin
         sat     = SAT_LO[DATA_W-1:0];
         clipped = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_q <= '0;
         clip_q   <= 1'b0;
      end else if (vld_pipe[2]) begin
         sample_q <= sat;
         clip_q   <= clipped;
      end else begin
         clip_q   <= 1'b0;
      end
   end

   assign bus.sample_out   = sample_q;
   assign bus.sample_valid = vld_pipe[STAGES];
   assign bus.clip         = clip_q;
endmodule

// File: tb/tb_two_tone_dds.sv
// Scoreboard bench for two_tone_dds: stimulus pushes model results, a monitor pops on sample_valid.
module tb_two_tone_dds;
   localparam int PW = 24;
   localparam int AW = 10;
   localparam int DW = 16;
   localparam real PI_TB = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   two_tone_dds_if #(.PHASE_W(PW), .DATA_W(DW)) bus ();

   two_tone_dds #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { int val; int clp; int due; } exp_t;
   exp_t sb[$];
   int   got[$];
   int   checks = 0, failures = 0;
   int   cyc = 0;
   int   run = 0, max_run = 0, valids = 0;
   bit   capture = 1'b0;
   int unsigned ph_a = 0, ph_b = 0;
   int unsigned mlfsr = 32'hACE1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Full-cycle sine evaluated directly from the phase address.
   function automatic int sine_at(input int unsigned addr);
      return int'(32767.0 * $sin(2.0 * PI_TB * (real'(addr) + 0.5) / real'(1 << AW)));
   endfunction

   function automatic int scale(input int s, input int amp);
      longint p;
      p = longint'(s) * longint'(amp);
      return int'(p >>> 15);
   endfunction

   task automatic step(input bit en, input bit clr);
      int unsigned aa, ab;
      int sum, v, c;
      bus.sample_en   = en;
      bus.phase_clear = clr;
      if (en) begin
         aa  = clr ? 0 : ph_a >> (PW - AW);
         ab  = clr ? 0 : ph_b >> (PW - AW);
         sum = scale(sine_at(aa), int'(bus.amp_a)) + scale(sine_at(ab), int'(bus.amp_b));
`ifdef TWO_TONE_DDS_DITHER_EN
         sum   = sum + int'(mlfsr & 1) - int'((mlfsr >> 1) & 1);
         mlfsr = (mlfsr >> 1) ^ ((mlfsr & 1) ? 32'hB400 : 32'h0);
`endif
         c = 0;
         v = sum;
         if (sum > 32767)       begin v = 32767;  c = 1; end
         else if (sum < -32768) begin v = -32768; c = 1; end
         sb.push_back('{val: v, clp: c, due: cyc + 4});
      end
      if (clr) begin
         ph_a = 0;
         ph_b = 0;
      end else if (en) begin
         ph_a = (ph_a + bus.fcw_a) & 32'hFF_FFFF;
         ph_b = (ph_b + bus.fcw_b) & 32'hFF_FFFF;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      bus.sample_en   = 1'b0;
      bus.phase_clear = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      check(name, sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic set_tones(input int unsigned fa, input int unsigned fb, input int unsigned aa, input int unsigned ab);
      bus.fcw_a = fa[PW-1:0];
      bus.fcw_b = fb[PW-1:0];
      bus.amp_a = aa[15:0];
      bus.amp_b = ab[15:0];
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (bus.sample_valid) begin
            valids++;
            run++;
            if (run > max_run) max_run = run;
            if (capture) got.push_back(int'(bus.sample_out));
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid: got sample %0d expected no valid (t=%0t)", bus.sample_out, $time);
            end else begin
               e = sb.pop_front();
               check("sample", int'(bus.sample_out), e.val);
               check("clip", int'(bus.clip), e.clp);
               check("latency", cyc, e.due);
            end
         end else begin
            run = 0;
            check("clip_idle", int'(bus.clip), 0);
         end
      end
   end

   initial begin
      int vmark;
      bus.sample_en   = 1'b0;
      bus.phase_clear = 1'b0;
      set_tones(0, 0, 32'h8000, 32'h8000);

      repeat (2) @(negedge clk);
      check("rst_sample_out", int'(bus.sample_out), 0);
      check("rst_valid", int'(bus.sample_valid), 0);
      check("rst_clip", int'(bus.clip), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // Phase 0, unity amplitude: 101 + 101
      step(1, 0);
      drain("drain_single");

      // Zero amplitude, arbitrary frequencies
      set_tones($urandom, $urandom, 0, 0);
      for (int i = 0; i < 100; i++) step(1, 0);
      drain("drain_zero_amp");

      // Positive clip at address 255
      set_tones(255 << 14, 255 << 14, 32'hFFFF, 32'hFFFF);
      step(0, 1);
      step(1, 0);
      step(1, 0);
      drain("drain_pos_clip");

      // Negative clip at address 767
      set_tones(767 << 14, 767 << 14, 32'hFFFF, 32'hFFFF);
      step(0, 1);
      step(1, 0);
      step(1, 0);
      drain("drain_neg_clip");

      // One full period of tone A, back-to-back strobes
      set_tones(1 << 14, 0, 32'h8000, 0);
      step(0, 1);
      got.delete();
      max_run = 0;
      capture = 1'b1;
      for (int i = 0; i < 1024; i++) step(1, 0);
      drain("drain_period");
      capture = 1'b0;
      check("period_run", max_run, 1024);
      check("period_count", got.size(), 1024);
      if (got.size() == 1024)
         for (int k = 0; k < 512; k += 37) check("antisym", got[k], -got[k + 512]);

      // Randomised frequencies, amplitudes, strobe gaps and clears
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0)
            set_tones($urandom, $urandom, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end
      drain("drain_random");

      // Reset with three samples in flight, then clear together with a strobe
      set_tones(300 << 14, 77 << 14, 32'h8000, 32'h4000);
      step(1, 0);
      step(1, 0);
      step(1, 0);
      bus.sample_en = 1'b0;
      #2 rst = 1'b0;
      sb.delete();
      ph_a  = 0;
      ph_b  = 0;
      mlfsr = 32'hACE1;
      @(negedge clk);
      check("midrst_valid", int'(bus.sample_valid), 0);
      check("midrst_sample_out", int'(bus.sample_out), 0);
      @(posedge clk);
      #3 rst = 1'b1;
      vmark = valids;
      repeat (8) @(posedge clk);
      #1;
      check("no_valid_after_reset", valids - vmark, 0);
      step(1, 0);
      step(1, 1);
      drain("drain_after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/two_tone_dds.md
Name: two_tone_dds

Overview:
- Upstream stimulus stage for the FIR filter.
- Generates two independent DDS sine tones, scales each by its own amplitude word, and sums them with saturation into one signed sample stream.
- Used to drive fir_filter.data_in for IMD, THD and frequency-response measurements.
- Fully pipelined; one new sample may be requested every clock.

Parameters:
- PHASE_W, 24, phase accumulator width.
- ADDR_W, 10, full-cycle table address width; top ADDR_W bits of phase; quarter table holds 2^(ADDR_W-2) entries.
- DATA_W, 16, signed output sample width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous reset, active-low.
- sample_en, input, 1, one-cycle strobe requesting one output sample (48 kHz tick).
- phase_clear, input, 1, synchronous clear of both phase accumulators.
- fcw_a, input, PHASE_W, frequency control word for tone A (unsigned).
- fcw_b, input, PHASE_W, frequency control word for tone B.
- amp_a, input, 16, tone A amplitude, unsigned Q1.15 (0x8000 = unity).
- amp_b, input, 16, tone B amplitude.
- sample_out, output, DATA_W, signed saturated sum of tones.
- sample_valid, output, 1, one-cycle pulse qualifying sample_out.
- clip, output, 1, high with sample_valid when the sum saturated.

Behaviour:
- Reset (rst=0, async):
  - Phase accumulators, all pipeline registers and valid bits go to 0.
  - sample_out=0, sample_valid=0, clip=0.
  - Reset mid-pipeline discards in-flight samples; no sample_valid follows release.
- Stage 0, edge E with sample_en=1:
  - Latch addr_x = phase_x[PHASE_W-1 -: ADDR_W] using the phase value before update.
  - Then phase_x <= phase_x + fcw_x, modulo 2^PHASE_W; wrap is silent.
- phase_clear:
  - When phase_clear=1, both phases load 0 instead of updating.
  - If sample_en=1 in the same cycle, the sampled address is 0 and the next phase is 0. Clear wins over increment.
- Stage 1, edge E+1: quarter-wave lookup.
  - Quadrant q = addr[ADDR_W-1:ADDR_W-2]; index i = low bits.
  - q=1 or q=3: use ~i (mirror).
  - q=2 or q=3: negate the table value.
  - Table entry k = round(32767*sin(2*pi*(k+0.5)/2^ADDR_W)). The half-step offset makes the mirror exact; no entry is 0.
- Stage 2, edge E+2: tone_x = (lut_x * {0,amp_x}) >>> 15.
  - Signed 17-bit amp; 33-bit product; arithmetic shift (floor).
  - Result kept at DATA_W+2 bits.
- Stage 3, edge E+3: sum = tone_a + tone_b at DATA_W+3 bits.
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register sample_out; sample_valid=1; clip=1 iff clamped.
- Latency: sample_valid high in the cycle after edge E+3 (4 clocks from strobe).
- Throughput: back-to-back strobes give back-to-back valid pulses, no stall.
- sample_en=0: no phase advance. sample_out holds its last value; sample_valid=0, clip=0.
- fcw/amp changes take effect on the next strobe; no glitch handling needed.

Optional Feature:
- TWO_TONE_DDS_DITHER_EN defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances once per stage-3 valid.
  - TPDF dither d = lfsr[0] - lfsr[1] (in {-1,0,+1}) is added to the sum before clamping.
- Undefined: no LFSR logic; output is deterministic as above.

Decomposition:
- Shared package dds_pkg:
  - PHASE_W, ADDR_W, DATA_W defaults; UNITY_AMP=16'h8000.
  - SAT_MAX/SAT_MIN constants.
  - Quarter-table depth constant; sample typedef (signed DATA_W).
- One sub-module: sine_quarter_lut.
  - Registered read; quadrant fold/negate logic inside.
  - Instantiated twice (tone A, tone B).

Test Plan:
- Phase 0, fcw_a=fcw_b=0, amp_a=amp_b=0x8000, single strobe -> one valid 4 clocks later; sample_out=+202 (101+101), clip=0.
- amp_a=amp_b=0, fcw arbitrary, 100 strobes -> every sample_out=0, clip=0.
- fcw_a=fcw_b=255<<14, amp=0xFFFF, two strobes after clear -> 2nd sample: tones 65532 each; sample_out=+32767, clip=1.
- fcw_a=fcw_b=767<<14 (addr 767), amp=0xFFFF -> 2nd sample tones -65533 each; sample_out=-32768, clip=1.
- fcw_a=2^14, fcw_b=0, amp_a=0x8000, amp_b=0, 1024 consecutive strobes -> one full period; sample[k] = -sample[k+512]; sample_valid high 1024 consecutive cycles.
- rst=0 pulsed while 3 samples in flight; phase_clear asserted together with sample_en -> no valid after release; next sample uses addr 0.
